// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register plus ALU operand select.
// Captures the decoded instruction at the stage boundary, resolves RAW
// hazards against the MEM and WB results, and drives the ALU operands.
// Optional feature macro: FORWARDING_EN. When it is undefined the
// mem_*/wb_* inputs are ignored, and upstream logic must stall on RAW hazards.
module ex_operand_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [3:0]  id_alu_fun,
  input  logic        id_srcA_sel,
  input  logic [1:0]  id_srcB_sel,
  input  logic        id_reg_write,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd_addr,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd_addr,
  input  logic [31:0] wb_result,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  alu_fun,
  output logic        ex_valid,
  output logic [4:0]  ex_rd_addr,
  output logic        ex_reg_write,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_pc
);

  // Control fields: these are cleared for bubbles.
  logic        valid_q, valid_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [3:0]  alu_fun_q, alu_fun_d;
  // Data fields: these may keep stale values under a bubble.
  logic [4:0]  rs1_addr_q, rs1_addr_d;
  logic [4:0]  rs2_addr_q, rs2_addr_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic        srca_q, srca_d;
  logic [1:0]  srcb_q, srcb_d;

  logic [31:0] fwd_rs1, fwd_rs2;

  // Next-state selection. Flush has priority over stall. A load with
  // id_valid low is treated as a bubble. Flush holds the data fields,
  // because nothing downstream consumes them while the control fields are clear.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    alu_fun_d   = alu_fun_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    srca_d      = srca_q;
    srcb_d      = srcb_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      rd_d        = 5'd0;
      alu_fun_d   = 4'd0;
    end else if (!stall) begin
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      pc_d        = id_pc;
      srca_d      = id_srcA_sel;
      srcb_d      = id_srcB_sel;
      valid_d     = id_valid;
      reg_write_d = id_valid & id_reg_write;
      rd_d        = id_valid ? id_rd_addr : 5'd0;
      alu_fun_d   = id_valid ? id_alu_fun : 4'd0;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      alu_fun_q   <= 4'd0;
      rs1_addr_q  <= 5'd0;
      rs2_addr_q  <= 5'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      pc_q        <= 32'd0;
      srca_q      <= 1'b0;
      srcb_q      <= 2'd0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      alu_fun_q   <= alu_fun_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      srca_q      <= srca_d;
      srcb_q      <= srcb_d;
    end
  end

`ifdef FORWARDING_EN
  // Forwarding: MEM has priority over WB, and x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (rs1_addr_q != 5'd0) begin
      if (mem_reg_write && (mem_rd_addr == rs1_addr_q))
        fwd_rs1 = mem_result;
      else if (wb_reg_write && (wb_rd_addr == rs1_addr_q))
        fwd_rs1 = wb_result;
    end
    if (rs2_addr_q != 5'd0) begin
      if (mem_reg_write && (mem_rd_addr == rs2_addr_q))
        fwd_rs2 = mem_result;
      else if (wb_reg_write && (wb_rd_addr == rs2_addr_q))
        fwd_rs2 = wb_result;
    end
  end
`else
  // Without forwarding, the operands come straight from the captured register data.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_reg_write, mem_rd_addr, mem_result,
                               wb_reg_write, wb_rd_addr, wb_result,
                               rs1_addr_q, rs2_addr_q};
`endif

  // Operand muxes. Store data always follows rs2, whatever srcB selects.
  always_comb begin
    A = srca_q ? imm_q : fwd_rs1;
    unique case (srcb_q)
      2'd0:    B = fwd_rs2;
      2'd1:    B = imm_q;
      2'd2:    B = pc_q;
      default: B = 32'd0;
    endcase
  end

  assign ex_store_data = fwd_rs2;
  assign alu_fun       = alu_fun_q;
  assign ex_valid      = valid_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = reg_write_q & valid_q;
  assign ex_pc         = pc_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: the stimulus pushes the expected
// outputs, and a negedge monitor pops each entry and compares it.
module tb_ex_operand_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, stall, flush, id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_fun;
  logic        id_srcA_sel;
  logic [1:0]  id_srcB_sel;
  logic        id_reg_write;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_result, wb_result;
  logic [31:0] A, B, ex_store_data, ex_pc;
  logic [3:0]  alu_fun;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd_addr;

  always #5 CLK = ~CLK;

  ex_operand_stage dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_alu_fun(id_alu_fun), .id_srcA_sel(id_srcA_sel),
    .id_srcB_sel(id_srcB_sel), .id_reg_write(id_reg_write),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_result(wb_result),
    .A(A), .B(B), .alu_fun(alu_fun), .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
  );

  typedef struct {
    string       name;
    bit          dchk;
    logic [31:0] a, b, st, pc;
    logic [3:0]  fun;
    logic        v, rw;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
      chk(e.name, "ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
      chk(e.name, "ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk(e.name, "alu_fun", {28'd0, alu_fun}, {28'd0, e.fun});
      if (e.dchk) begin
        chk(e.name, "A", A, e.a);
        chk(e.name, "B", B, e.b);
        chk(e.name, "store", ex_store_data, e.st);
        chk(e.name, "pc", ex_pc, e.pc);
      end
    end
  end

  task automatic push_exp(input string nm, input bit dchk, input logic [31:0] a, b, st, pc,
                          input logic [3:0] fun, input logic v, rw, input logic [4:0] rd);
    exp_t e;
    e.name = nm; e.dchk = dchk; e.a = a; e.b = b; e.st = st; e.pc = pc;
    e.fun = fun; e.v = v; e.rw = rw; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2,
                          input logic [31:0] imm, pc, input logic [4:0] rd,
                          input logic [3:0] fun, input logic sa, input logic [1:0] sbs,
                          input logic rw);
    id_valid = v; id_rs1_addr = a1; id_rs1_data = d1; id_rs2_addr = a2; id_rs2_data = d2;
    id_imm = imm; id_pc = pc; id_rd_addr = rd; id_alu_fun = fun;
    id_srcA_sel = sa; id_srcB_sel = sbs; id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mw; mem_rd_addr = mrd; mem_result = mres;
    wb_reg_write = ww; wb_rd_addr = wrd; wb_result = wres;
  endtask

  task automatic next_vec();
    @(negedge CLK); #1;
  endtask

  task automatic edge_wait();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0, 1'b0, 2'd0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset wins over a valid instruction.
    next_vec();
    drive_id(1'b1, 5'd1, 32'h99, 5'd2, 32'h98, 32'h5, 32'h80, 5'd7, 4'd5, 1'b0, 2'd0, 1'b1);
    edge_wait();
    push_exp("reset", 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 5'd0);

    // Basic load.
    next_vec(); RST = 1'b0;
    drive_id(1'b1, 5'd1, 32'h10, 5'd2, 32'h20, 32'h7, 32'h40, 5'd5, 4'd0, 1'b0, 2'd0, 1'b1);
    edge_wait();
    push_exp("basic", 1, 32'h10, 32'h20, 32'h20, 32'h40, 4'd0, 1'b1, 1'b1, 5'd5);

    // MEM and WB both match rs1, so MEM wins.
    next_vec();
    drive_id(1'b1, 5'd3, 32'h1111, 5'd4, 32'h2222, 32'h0, 32'h44, 5'd6, 4'd2, 1'b0, 2'd0, 1'b1);
    set_fwd(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB);
    edge_wait();
    push_exp("fwd_mem", 1, FWD ? 32'hAAAA : 32'h1111, 32'h2222, 32'h2222, 32'h44, 4'd2, 1'b1, 1'b1, 5'd6);

    // Stall while MEM drops out, so the same instruction now picks up WB.
    next_vec(); stall = 1'b1;
    drive_id(1'b1, 5'd9, 32'h9999, 5'd9, 32'h9999, 32'h9, 32'h99, 5'd9, 4'd9, 1'b1, 2'd3, 1'b0);
    edge_wait();
    mem_reg_write = 1'b0;
    push_exp("fwd_wb_stall", 1, FWD ? 32'hBBBB : 32'h1111, 32'h2222, 32'h2222, 32'h44, 4'd2, 1'b1, 1'b1, 5'd6);

    // x0 is never forwarded; WB forwards to rs2.
    next_vec(); stall = 1'b0;
    drive_id(1'b1, 5'd0, 32'h0, 5'd4, 32'h2222, 32'h0, 32'h48, 5'd7, 4'd2, 1'b0, 2'd0, 1'b1);
    set_fwd(1'b1, 5'd0, 32'hCCCC, 1'b1, 5'd4, 32'hDDDD);
    edge_wait();
    push_exp("fwd_x0", 1, 32'h0, FWD ? 32'hDDDD : 32'h2222, FWD ? 32'hDDDD : 32'h2222,
             32'h48, 4'd2, 1'b1, 1'b1, 5'd7);

    // lui: A = imm, B = zero.
    next_vec();
    drive_id(1'b1, 5'd1, 32'h77, 5'd2, 32'h88, 32'h12345000, 32'h100, 5'd8, 4'b1001, 1'b1, 2'd3, 1'b1);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    edge_wait();
    push_exp("lui", 1, 32'h12345000, 32'h0, 32'h88, 32'h100, 4'b1001, 1'b1, 1'b1, 5'd8);

    // auipc-style: B = pc.
    next_vec();
    drive_id(1'b1, 5'd1, 32'h77, 5'd2, 32'h88, 32'h12345000, 32'h100, 5'd8, 4'b0000, 1'b1, 2'd2, 1'b1);
    edge_wait();
    push_exp("auipc", 1, 32'h12345000, 32'h100, 32'h88, 32'h100, 4'd0, 1'b1, 1'b1, 5'd8);

    // Store: B = imm, and the store data is the forwarded rs2.
    next_vec();
    drive_id(1'b1, 5'd1, 32'h300, 5'd9, 32'h11, 32'h8, 32'h104, 5'd0, 4'd0, 1'b0, 2'd1, 1'b0);
    set_fwd(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'd0);
    edge_wait();
    push_exp("store", 1, 32'h300, 32'h8, FWD ? 32'h55 : 32'h11, 32'h104, 4'd0, 1'b1, 1'b0, 5'd0);

    // Reference instruction for the stall sequence.
    next_vec();
    drive_id(1'b1, 5'd1, 32'h1234, 5'd2, 32'h5678, 32'h9, 32'h200, 5'd10, 4'd3, 1'b0, 2'd0, 1'b1);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    edge_wait();
    push_exp("pre_stall", 1, 32'h1234, 32'h5678, 32'h5678, 32'h200, 4'd3, 1'b1, 1'b1, 5'd10);

    for (int i = 0; i < 3; i++) begin
      next_vec(); stall = 1'b1;
      drive_id(1'b1, 5'd3, 32'hF000 + i, 5'd4, 32'hE000 + i, 32'h20 + i, 32'h300 + i,
               5'd11 + i[4:0], 4'd7, 1'b1, 2'd1, 1'b0);
      edge_wait();
      push_exp("stall_hold", 1, 32'h1234, 32'h5678, 32'h5678, 32'h200, 4'd3, 1'b1, 1'b1, 5'd10);
    end

    // Flush beats stall.
    next_vec(); flush = 1'b1;
    edge_wait();
    push_exp("flush_stall", 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 5'd0);

    // A load with id_valid low becomes a bubble.
    next_vec(); flush = 1'b0; stall = 1'b0;
    drive_id(1'b0, 5'd1, 32'h1, 5'd2, 32'h2, 32'h3, 32'h4, 5'd12, 4'd5, 1'b0, 2'd0, 1'b1);
    edge_wait();
    push_exp("bubble", 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 5'd0);

    // Valid load, then reset asserted during a stall.
    next_vec();
    drive_id(1'b1, 5'd5, 32'hABCD, 5'd6, 32'h1, 32'h10, 32'h400, 5'd13, 4'd4, 1'b0, 2'd1, 1'b0);
    edge_wait();
    push_exp("reload", 1, 32'hABCD, 32'h10, 32'h1, 32'h400, 4'd4, 1'b1, 1'b0, 5'd13);

    next_vec(); stall = 1'b1; RST = 1'b1;
    edge_wait();
    push_exp("reset_in_stall", 1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 5'd0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-select stage feeding the ALU. It captures decoded instruction fields at the stage boundary, resolves register hazards by forwarding MEM and WB results, and muxes the final 32-bit A and B operands plus the 4-bit function code into the ALU. It also carries the destination register, PC and store data forward to the EX/MEM boundary.

## Interface
- No parameters; all widths fixed (XLEN 32, 5-bit register addresses, 4-bit alu_fun).
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  replace captured instruction with a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1_data, id_rs2_data  in  32 each  register-file read data.
- id_imm  in  32  sign/zero-extended immediate (U-imm pre-shifted for lui/auipc).
- id_pc  in  32  instruction PC.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each  register addresses.
- id_alu_fun  in  4  ALU function code.
- id_srcA_sel  in  1  0 = rs1, 1 = imm.
- id_srcB_sel  in  2  0 = rs2, 1 = imm, 2 = pc, 3 = zero.
- id_reg_write  in  1  instruction writes rd.
- mem_reg_write, mem_rd_addr, mem_result  in  1/5/32  EX/MEM forwarding source.
- wb_reg_write, wb_rd_addr, wb_result  in  1/5/32  MEM/WB forwarding source.
- A, B  out  32 each  ALU operands.
- alu_fun  out  4  ALU function code.
- ex_valid  out  1  stage holds a real instruction.
- ex_rd_addr  out  5  destination; 0 for bubbles.
- ex_reg_write  out  1  qualified write enable (0 for bubbles).
- ex_store_data  out  32  forwarded rs2 value, independent of srcB_sel.
- ex_pc  out  32  registered PC.

## Operation
- Stage register update priority per rising edge: RST > flush > stall > load.
- RST: all registered fields to 0 (ex_valid 0, alu_fun 4'b0000, rd 0, data 0); A = B = 0, ex_store_data = 0 after reset.
- flush: ex_valid, ex_reg_write, ex_rd_addr, alu_fun cleared; data fields may keep old values but must not be forwarded or written. Flush wins over simultaneous stall.
- stall (no flush): every stage register holds.
- load: all id_* fields captured; if id_valid = 0, captured as bubble (same as flush).
- Forwarding, per source operand (rs1, rs2), combinational on registered addresses:
  - addr == 0: register data (never forward x0).
  - mem_reg_write && mem_rd_addr == addr: mem_result (MEM priority).
  - else wb_reg_write && wb_rd_addr == addr: wb_result.
  - else registered file data.
- A = srcA_sel ? imm : fwd_rs1. B per srcB_sel from {fwd_rs2, imm, pc, 32'h0}.
- ex_store_data = fwd_rs2 always.
- Load-use hazards are not detected here; upstream stalls.

## Timing
- One-cycle latency: id_* sampled at edge N appear on stage outputs after edge N.
- A, B, ex_store_data are combinational from stage registers and forwarding inputs; mem_*/wb_* changes within a cycle propagate same cycle.
- ex_reg_write = registered id_reg_write && ex_valid.
- During stall, A/B keep tracking forwarding inputs (forwarded value may update while held).
- RST asserted mid-stall or mid-flush: reset values after that edge.

## Configuration
- FORWARDING_EN defined: forwarding as above.
- Undefined: mem_*/wb_* ignored; fwd_rs1/fwd_rs2 are registered register-file data; upstream must stall RAW hazards. All other behaviour unchanged.

## Test plan
- Reset: RST=1 one edge with id_valid=1 -> ex_valid=0, alu_fun=0, A=B=0, ex_rd_addr=0.
- Basic load: rs1=0x10, rs2=0x20, srcA_sel=0, srcB_sel=0, alu_fun=4'b0000, rd=5 -> next cycle A=0x10, B=0x20, ex_rd_addr=5, ex_valid=1.
- Forward priority: rs1_addr=3, mem_rd=3 result 0xAAAA, wb_rd=3 result 0xBBBB, both write -> A=0xAAAA; drop mem_reg_write -> A=0xBBBB; rs1_addr=0 with mem_rd=0 -> A=0.
- Operand mux: lui imm=0x12345000, srcA_sel=1, alu_fun=4'b1001 -> A=0x12345000; srcB_sel=2 pc=0x100 -> B=0x100; srcB_sel=3 -> B=0; store with srcB_sel=1, rs2 forwarded 0x55 -> ex_store_data=0x55.
- Stall/flush: stall=1 for 3 cycles with changing id_* -> outputs held; stall=1 and flush=1 together -> ex_valid=0, ex_reg_write=0, ex_rd_addr=0.
- FORWARDING_EN off: same as forward-priority stimulus -> A equals registered rs1 data.
